// File: rtl/game_key_events_if.sv
// Byte stream from the PS/2 receiver into the key-event parser.
interface game_key_events_if;
    logic [7:0] din;
    logic       dinValid;

    modport master (output din, output dinValid);
    modport slave  (input  din, input  dinValid);
endinterface

// File: rtl/game_key_events.sv
// PS/2 set-2 scan-code parser producing game-control pulses and held-key levels.
// Optional: GAME_KEY_TYPEMATIC_FILTER_EN suppresses make pulses from typematic repeats.
//
// state   | meaning
// Sidle   | waiting for a make code or a prefix
// Sext    | E0 seen, expecting an extended make or F0
// Sbrk    | F0 seen, expecting the released key
// SextBrk | E0 F0 seen, expecting the released extended key
module game_key_events #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TW             = 16
) (
    input  logic                     clk,
    input  logic                     resetN,
    game_key_events_if.slave         kbd,
    output logic                     start,
    output logic                     risingSpace,
    output logic                     brakeSpace,
    output logic                     spaceHeld,
    output logic [3:0]               numKey,
    output logic                     leftKey,
    output logic                     rightKey
);
    typedef enum logic [1:0] {Sidle, Sext, Sbrk, SextBrk} state_t;

    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_SPACE = 8'h29;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_D1    = 8'h16;
    localparam logic [7:0] K_D2    = 8'h1E;
    localparam logic [7:0] K_D3    = 8'h26;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] tcnt;
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
    logic          enterHeld;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= Sidle;
            tcnt        <= '0;
            start       <= 1'b0;
            risingSpace <= 1'b0;
            brakeSpace  <= 1'b0;
            spaceHeld   <= 1'b0;
            numKey      <= 4'd0;
            leftKey     <= 1'b0;
            rightKey    <= 1'b0;
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
            enterHeld   <= 1'b0;
`endif
        end else begin
            start       <= 1'b0;
            risingSpace <= 1'b0;
            brakeSpace  <= 1'b0;
            if (kbd.dinValid) begin
                // A byte arriving on the expiry cycle is parsed in the current state.
                tcnt <= '0;
                unique case (state)
                    Sidle: begin
                        case (kbd.din)
                            K_EXT:   state <= Sext;
                            K_BRK:   state <= Sbrk;
                            K_SPACE: begin
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
                                risingSpace <= ~spaceHeld;
`else
                                risingSpace <= 1'b1;
`endif
                                spaceHeld <= 1'b1;
                            end
                            K_ENTER: begin
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
                                start     <= ~enterHeld;
                                enterHeld <= 1'b1;
`else
                                start <= 1'b1;
`endif
                            end
                            K_D1:    numKey <= 4'd1;
                            K_D2:    numKey <= 4'd2;
                            K_D3:    numKey <= 4'd3;
                            default: state <= Sidle;
                        endcase
                    end
                    Sext: begin
                        case (kbd.din)
                            K_BRK:   state <= SextBrk;
                            K_EXT:   state <= Sext;
                            K_LEFT:  begin leftKey  <= 1'b1; state <= Sidle; end
                            K_RIGHT: begin rightKey <= 1'b1; state <= Sidle; end
                            default: state <= Sidle;
                        endcase
                    end
                    Sbrk: begin
                        state <= Sidle;
                        case (kbd.din)
                            K_BRK:   state <= Sbrk;
                            K_EXT:   state <= Sext;
                            K_SPACE: begin
                                brakeSpace <= 1'b1;
                                spaceHeld  <= 1'b0;
                            end
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
                            K_ENTER: enterHeld <= 1'b0;
`endif
                            // A digit release only clears numKey if it is the digit shown.
                            K_D1:    if (numKey == 4'd1) numKey <= 4'd0;
                            K_D2:    if (numKey == 4'd2) numKey <= 4'd0;
                            K_D3:    if (numKey == 4'd3) numKey <= 4'd0;
                            default: state <= Sidle;
                        endcase
                    end
                    SextBrk: begin
                        state <= Sidle;
                        if (kbd.din == K_LEFT)  leftKey  <= 1'b0;
                        if (kbd.din == K_RIGHT) rightKey <= 1'b0;
                    end
                    default: state <= Sidle;
                endcase
            end else if (state != Sidle) begin
                if (tcnt == T_LAST) begin
                    state <= Sidle;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_game_key_events.sv
// Directed vector bench for game_key_events, with hand sequences for timeout and reset.
module tb_game_key_events;
    localparam int TO = 16;
`ifdef GAME_KEY_TYPEMATIC_FILTER_EN
    localparam logic TF = 1'b1;
`else
    localparam logic TF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start, risingSpace, brakeSpace, spaceHeld, leftKey, rightKey;
    logic [3:0] numKey;
    logic [9:0] obs;

    game_key_events_if kbd ();

    game_key_events #(.TIMEOUT_CYCLES(TO), .TW(5)) dut (
        .clk(clk), .resetN(resetN), .kbd(kbd),
        .start(start), .risingSpace(risingSpace), .brakeSpace(brakeSpace),
        .spaceHeld(spaceHeld), .numKey(numKey), .leftKey(leftKey), .rightKey(rightKey)
    );

    always #5 clk = ~clk;

    assign obs = {start, risingSpace, brakeSpace, spaceHeld, numKey, leftKey, rightKey};

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [9:0] e(logic st, logic rs, logic bs, logic sh,
                                     logic [3:0] nk, logic lk, logic rk);
        return {st, rs, bs, sh, nk, lk, rk};
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input logic [9:0] x);
        vec_t r;
        r.v = v; r.d = d; r.exp = x;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [9:0] x);
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL %s got %b want %b (st rs bs sh nk[4] lk rk)", name, obs, x);
        end
    endtask

    // Called right after a posedge; drives one cycle and returns #1 after the sampling edge.
    task automatic step(input logic v, input logic [7:0] d);
        kbd.din = d;
        kbd.dinValid = v;
        @(posedge clk);
        #1;
        kbd.dinValid = 1'b0;
    endtask

    initial begin
        kbd.din = 8'h00;
        kbd.dinValid = 1'b0;
        #23 resetN = 1'b1;
        @(posedge clk); #1;
        check("reset", e(0,0,0,0,0,0,0));

        add(1,8'h29, e(0,1,0,1,0,0,0));
        add(0,8'h00, e(0,0,0,1,0,0,0));
        add(1,8'hF0, e(0,0,0,1,0,0,0));
        add(1,8'h29, e(0,0,1,0,0,0,0));
        add(0,8'h00, e(0,0,0,0,0,0,0));
        add(1,8'h1E, e(0,0,0,0,2,0,0));
        add(1,8'h26, e(0,0,0,0,3,0,0));
        add(1,8'hF0, e(0,0,0,0,3,0,0));
        add(1,8'h1E, e(0,0,0,0,3,0,0));
        add(1,8'hF0, e(0,0,0,0,3,0,0));
        add(1,8'h26, e(0,0,0,0,0,0,0));
        add(1,8'hE0, e(0,0,0,0,0,0,0));
        add(1,8'h6B, e(0,0,0,0,0,1,0));
        add(1,8'hE0, e(0,0,0,0,0,1,0));
        add(1,8'h74, e(0,0,0,0,0,1,1));
        add(1,8'hE0, e(0,0,0,0,0,1,1));
        add(1,8'hF0, e(0,0,0,0,0,1,1));
        add(1,8'h6B, e(0,0,0,0,0,0,1));
        add(1,8'h6B, e(0,0,0,0,0,0,1));
        add(1,8'hE0, e(0,0,0,0,0,0,1));
        add(1,8'hF0, e(0,0,0,0,0,0,1));
        add(1,8'h74, e(0,0,0,0,0,0,0));
        add(1,8'h29, e(0,1,0,1,0,0,0));
        add(1,8'h29, e(0,~TF,0,1,0,0,0));
        add(1,8'h29, e(0,~TF,0,1,0,0,0));
        add(1,8'hF0, e(0,0,0,1,0,0,0));
        add(1,8'h29, e(0,0,1,0,0,0,0));
        add(1,8'hF0, e(0,0,0,0,0,0,0));
        add(1,8'h29, e(0,0,1,0,0,0,0));
        add(1,8'h5A, e(1,0,0,0,0,0,0));
        add(1,8'h5A, e(~TF,0,0,0,0,0,0));
        add(1,8'hF0, e(0,0,0,0,0,0,0));
        add(1,8'h5A, e(0,0,0,0,0,0,0));
        add(1,8'h5A, e(1,0,0,0,0,0,0));
        add(1,8'hE1, e(0,0,0,0,0,0,0));
        add(1,8'hAA, e(0,0,0,0,0,0,0));
        add(1,8'hFA, e(0,0,0,0,0,0,0));
        add(1,8'hF0, e(0,0,0,0,0,0,0));
        add(1,8'hE0, e(0,0,0,0,0,0,0));
        add(1,8'h6B, e(0,0,0,0,0,1,0));
        add(1,8'hE0, e(0,0,0,0,0,1,0));
        add(1,8'hF0, e(0,0,0,0,0,1,0));
        add(1,8'h6B, e(0,0,0,0,0,0,0));
        add(1,8'hE0, e(0,0,0,0,0,0,0));
        add(1,8'hE0, e(0,0,0,0,0,0,0));
        add(1,8'h74, e(0,0,0,0,0,0,1));
        add(1,8'hE0, e(0,0,0,0,0,0,1));
        add(1,8'hF0, e(0,0,0,0,0,0,1));
        add(1,8'h74, e(0,0,0,0,0,0,0));
        add(1,8'hE0, e(0,0,0,0,0,0,0));
        add(1,8'h29, e(0,0,0,0,0,0,0));
        add(1,8'h29, e(0,1,0,1,0,0,0));
        add(1,8'hF0, e(0,0,0,1,0,0,0));
        add(1,8'h29, e(0,0,1,0,0,0,0));
        add(1,8'h16, e(0,0,0,0,1,0,0));
        add(1,8'hF0, e(0,0,0,0,1,0,0));
        add(1,8'h16, e(0,0,0,0,0,0,0));
        add(0,8'h00, e(0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // F0 then TO idle clocks: prefix abandoned, 29 is a make.
        step(1, 8'hF0);
        for (int i = 0; i < TO; i++) step(0, 8'h00);
        check("timeout_idle", e(0,0,0,0,0,0,0));
        step(1, 8'h29);
        check("timeout_make", e(0,1,0,1,0,0,0));

        // F0 then TO-1 idle clocks: still inside break prefix.
        step(1, 8'hF0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00);
        step(1, 8'h29);
        check("pre_timeout_break", e(0,0,1,0,0,0,0));

        // Held levels survive a timeout; the following 6B is a bare code.
        step(1, 8'hE0);
        step(1, 8'h6B);
        step(1, 8'hE0);
        for (int i = 0; i < TO; i++) step(0, 8'h00);
        step(1, 8'h6B);
        check("timeout_keeps_level", e(0,0,0,0,0,1,0));
        step(1, 8'hE0);
        step(1, 8'hF0);
        step(1, 8'h6B);
        check("left_release", e(0,0,0,0,0,0,0));

        // Asynchronous reset mid-sequence after E0.
        step(1, 8'h29);
        step(1, 8'hE0);
        step(1, 8'h6B);
        step(1, 8'h1E);
        check("pre_reset", e(0,0,0,1,2,1,0));
        step(1, 8'hE0);
        #2 resetN = 1'b0;
        #1 check("async_reset", e(0,0,0,0,0,0,0));
        #3 resetN = 1'b1;
        @(posedge clk); #1;
        step(1, 8'h6B);
        check("after_reset_6B", e(0,0,0,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
